mcycle_sequencer: RTL

//  Generates the T-step / M-cycle timing for every instruction microcode block in the control unit.
//  o_Cycle_Step is the one-hot T-state inside an M-cycle; o_Cycle_Count is the one-hot M-cycle index within the current instruction.
//  o_Active gates every microcode block.

---
 rtl/mcycle_sequencer.sv | 96 +++++++++
 1 files changed

// File: rtl/mcycle_sequencer.sv
// T-step / M-cycle timing generator for the microcode control unit.
// Tracks one-hot T-state and M-cycle position, handles stalls, HALT entry/wake and M-cycle overflow.
module mcycle_sequencer #(
  parameter int unsigned STEP_W  = 4,
  parameter int unsigned COUNT_W = 8
) (
  input  logic               i_Clk,
  input  logic               i_Reset_n,
  input  logic               i_Stall,
  input  logic               i_IR_Fetch,
  input  logic               i_Halt_Req,
  input  logic               i_Wake,
  output logic [STEP_W-1:0]  o_Cycle_Step,
  output logic [COUNT_W-1:0] o_Cycle_Count,
  output logic [2:0]         o_M_Index,
  output logic               o_Active,
  output logic               o_Instr_Start,
  output logic               o_Halted,
  output logic               o_Seq_Error
);

  localparam int unsigned IDX_W = 3;

  typedef enum logic {
    S_RUN  = 1'b0,
    S_HALT = 1'b1
  } state_t;

  state_t             r_state;
  logic [STEP_W-1:0]  r_step;
  logic [COUNT_W-1:0] r_count;
  logic [IDX_W-1:0]   r_idx;
  logic               r_err;

  logic w_run;
  logic w_advance;

  assign w_run     = (r_state == S_RUN);
  assign w_advance = w_run & ~i_Stall;

  // Step rotates every unstalled clock; count moves only on the last T-state.
  always_ff @(posedge i_Clk or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      r_state <= S_RUN;
      r_step  <= STEP_W'(1);
      r_count <= COUNT_W'(1);
      r_idx   <= IDX_W'(0);
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        S_RUN: begin
          if (w_advance) begin
            r_step <= {r_step[STEP_W-2:0], r_step[STEP_W-1]};
            if (r_step[STEP_W-1]) begin
              if (i_IR_Fetch) begin
                r_count <= COUNT_W'(1);
                r_idx   <= IDX_W'(0);
                if (i_Halt_Req && !i_Wake) begin
                  r_state <= S_HALT;
                end
              end else if (r_count[COUNT_W-1]) begin
                // Microcode never requested a fetch: recover to M1 and flag it.
                r_count <= COUNT_W'(1);
                r_idx   <= IDX_W'(0);
                r_err   <= 1'b1;
              end else begin
                r_count <= {r_count[COUNT_W-2:0], 1'b0};
                r_idx   <= r_idx + IDX_W'(1);
              end
            end
          end
        end
        S_HALT: begin
          r_step  <= STEP_W'(1);
          r_count <= COUNT_W'(1);
          r_idx   <= IDX_W'(0);
          if (i_Wake) begin
            r_state <= S_RUN;
          end
        end
        default: begin
          r_state <= S_RUN;
        end
      endcase
    end
  end

  assign o_Cycle_Step  = r_step;
  assign o_Cycle_Count = r_count;
  assign o_M_Index     = r_idx;
  assign o_Halted      = (r_state == S_HALT);
  assign o_Seq_Error   = r_err;
  assign o_Active      = w_advance;
  assign o_Instr_Start = w_advance & r_step[0] & r_count[0];

endmodule
